// File: rtl/byte_stream_packer.sv
// byte_stream_packer: widens an 8-bit ready/valid byte stream into
// BYTE_COUNT-byte words with per-lane strobes and end-of-packet flag.
// Lane i of the word carries the i-th byte of the word; lane 0 is the
// first byte received. A byte with in_last flushes a partial word.

// One byte lane: its slice of the accumulator and of the holding register.
module byte_stream_packer_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,        // accepted byte targets this lane
  input  logic       load,      // completing byte: move acc into holding reg
  input  logic       hit,       // lane counter points at this lane
  input  logic       keep,      // lane index <= lane counter
  input  logic [7:0] in_data,
  output logic [7:0] out_byte,
  output logic       strb
);
  logic [7:0] acc;

  // Accumulator lane: captures a byte, cleared whenever a word is emitted
  // so unfilled lanes of the next partial word read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (load) acc <= '0;
    else if (wr)   acc <= in_data;
  end

  // Holding lane: the completing byte bypasses acc in its own lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_byte <= '0;
      strb     <= 1'b0;
    end else if (load) begin
      out_byte <= hit ? in_data : acc;
      strb     <= keep;
    end
  end
endmodule

module byte_stream_packer #(
  parameter int BYTE_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  output logic [8*BYTE_COUNT-1:0] out_data,
  output logic [BYTE_COUNT-1:0]   out_strb,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int CW = $clog2(BYTE_COUNT);

  logic [CW-1:0]                cnt;
  logic                         accept;
  logic                         complete;
  logic [BYTE_COUNT-1:0][7:0]   lane_q;

  // Intake only while the holding register is free or draining this edge.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign complete = accept & (in_last | (cnt == CW'(BYTE_COUNT - 1)));
  assign out_data = lane_q;

  // Lane counter: advances per accepted byte, wraps on word completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (complete) cnt <= '0;
    else if (accept)   cnt <= cnt + 1'b1;
  end

  // Holding valid/last: reload on completion, otherwise drop on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < BYTE_COUNT; i++) begin : g_lane
    byte_stream_packer_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (accept & (cnt == CW'(i))),
      .load     (complete),
      .hit      (cnt == CW'(i)),
      .keep     (int'(cnt) >= i),
      .in_data  (in_data),
      .out_byte (lane_q[i]),
      .strb     (out_strb[i])
    );
  end
endmodule

// File: tb/tb_byte_stream_packer.sv
// Bench for byte_stream_packer (BYTE_COUNT=4): directed vector table,
// hand-written back-to-back and reset sequences, and a randomized
// packet run checked against a chunking reference model.
module tb_byte_stream_packer;
  localparam int BC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid, in_last, in_ready;
  logic [8*BC-1:0] out_data;
  logic [BC-1:0] out_strb;
  logic          out_last, out_valid, out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  byte_stream_packer #(.BYTE_COUNT(BC)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .out_data(out_data),
    .out_strb(out_strb), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic        e_last;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [7:0] d, logic l, logic ordy,
                              logic e_rdy, logic e_ov, logic [31:0] e_data,
                              logic [3:0] e_strb, logic e_last);
    vec_t v;
    v.iv = iv; v.d = d; v.l = l; v.ordy = ordy; v.e_rdy = e_rdy;
    v.e_ov = e_ov; v.e_data = e_data; v.e_strb = e_strb; v.e_last = e_last;
    return v;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } word_t;

  vec_t  vecs[$];
  word_t exp_q[$];
  logic [7:0] bq_d[$];
  logic       bq_l[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
  endtask

  initial begin
    logic [7:0] b12[12];
    int         lens;
    int         cyc;
    logic       acc_b, hs_out, stalled;
    logic [31:0] h_data;
    logic [3:0]  h_strb;
    logic        h_last;
    word_t       w;

    // ---------------- reset state ----------------
    rst_n = 1'b0; out_ready = 1'b1; idle();
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data",  out_data,  0);
    chk("reset out_strb",  out_strb,  0);
    chk("reset out_last",  out_last,  0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("reset in_ready", in_ready, 1);

    // ---------------- vector table ----------------
    // full 4-byte packet
    vecs.push_back(mk(1, 8'h11, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h22, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h33, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h44, 1, 1, 1, 1, 32'h44332211, 4'hf, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0));
    // partial packet
    vecs.push_back(mk(1, 8'hA5, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h5A, 1, 1, 1, 1, 32'h00005AA5, 4'h3, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0));
    // backpressure: 0x01..0x08, out_ready low from first completion
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 1, 1, 32'h04030201, 4'hf, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 8'h05, 0, 0, 0, 1, 32'h04030201, 4'hf, 0));
    vecs.push_back(mk(1, 8'h05, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h06, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h07, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h08, 1, 1, 1, 1, 32'h08070605, 4'hf, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      in_valid = vecs[k].iv; in_data = vecs[k].d; in_last = vecs[k].l;
      out_ready = vecs[k].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", k), in_ready, vecs[k].e_rdy);
      tick();
      chk($sformatf("vec%0d out_valid", k), out_valid, vecs[k].e_ov);
      if (vecs[k].e_ov) begin
        chk($sformatf("vec%0d out_data", k), out_data, vecs[k].e_data);
        chk($sformatf("vec%0d out_strb", k), out_strb, vecs[k].e_strb);
        chk($sformatf("vec%0d out_last", k), out_last, vecs[k].e_last);
      end
    end
    idle(); out_ready = 1'b1; tick();

    // ---------------- back-to-back 12 bytes ----------------
    foreach (b12[i]) b12[i] = 8'($urandom);
    for (int k = 1; k <= 13; k++) begin
      if (k <= 12) push_byte(b12[k-1], k == 12); else idle();
      tick();
      chk($sformatf("b2b cyc%0d out_valid", k), out_valid, (k % 4) == 0 && k <= 12);
      if ((k % 4) == 0 && k <= 12) begin
        chk($sformatf("b2b word%0d data", k/4), out_data,
            {b12[k-1], b12[k-2], b12[k-3], b12[k-4]});
        chk($sformatf("b2b word%0d strb", k/4), out_strb, 4'hf);
        chk($sformatf("b2b word%0d last", k/4), out_last, k == 12);
      end
    end

    // ---------------- reset mid-operation ----------------
    push_byte(8'h77, 0); tick();
    push_byte(8'h88, 0); tick();
    idle(); #2 rst_n = 1'b0; #1;
    chk("rst partial out_valid", out_valid, 0);
    @(negedge clk); rst_n = 1'b1; tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin push_byte(8'hC0 + 8'(i), 0); tick(); end
    idle();
    chk("rst held pre out_valid", out_valid, 1);
    #2 rst_n = 1'b0; #1;
    chk("rst held out_valid", out_valid, 0);
    chk("rst held out_data", out_data, 0);
    chk("rst held out_strb", out_strb, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; tick();
    push_byte(8'hDE, 0); tick();
    push_byte(8'hAD, 1); tick();
    idle();
    chk("post-rst out_valid", out_valid, 1);
    chk("post-rst out_data", out_data, 32'h0000ADDE);
    chk("post-rst out_strb", out_strb, 4'h3);
    chk("post-rst out_last", out_last, 1);
    tick();

    // ---------------- randomized packets ----------------
    for (int p = 0; p < 1000; p++) begin
      lens = $urandom_range(20, 1);
      for (int b = 0; b < lens; b++) begin
        bq_d.push_back(8'($urandom));
        bq_l.push_back(b == lens - 1);
      end
      // reference: chop packet into BC-byte chunks, zero-filled tail
      for (int s = 0; s < lens; s += BC) begin
        w.data = '0; w.strb = '0;
        for (int j = 0; j < BC && s + j < lens; j++) begin
          w.data[8*j +: 8] = bq_d[bq_d.size() - lens + s + j];
          w.strb[j] = 1'b1;
        end
        w.last = (s + BC >= lens);
        exp_q.push_back(w);
      end
    end

    cyc = 0; stalled = 1'b0; h_data = '0; h_strb = '0; h_last = 1'b0;
    while ((bq_d.size() > 0 || exp_q.size() > 0) && cyc < 80000) begin
      if (stalled) begin
        if (!out_valid || out_data !== h_data || out_strb !== h_strb || out_last !== h_last)
          chk("stall stability", {out_valid, out_last, out_strb, out_data},
              {1'b1, h_last, h_strb, h_data});
        else chk("stall stability", out_data, h_data);
      end
      if (bq_d.size() > 0 && ($urandom % 4) != 0) push_byte(bq_d[0], bq_l[0]);
      else idle();
      out_ready = ($urandom % 3) != 0;
      #1;
      acc_b  = in_valid & in_ready;
      hs_out = out_valid & out_ready;
      if (hs_out) begin
        if (exp_q.size() == 0) chk("rand extra word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("rand out_data", out_data, w.data);
          chk("rand out_strb", out_strb, w.strb);
          chk("rand out_last", out_last, w.last);
        end
      end
      stalled = out_valid & !out_ready;
      h_data = out_data; h_strb = out_strb; h_last = out_last;
      @(posedge clk);
      if (acc_b) begin void'(bq_d.pop_front()); void'(bq_l.pop_front()); end
      #1;
      cyc++;
    end
    chk("rand bytes drained", bq_d.size(), 0);
    chk("rand words drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
